// File: rtl/trig_mon_pkg.sv
// Shared types and defaults for the trigger event monitor.
// State encodings are fixed because software reads them through the state port.
package trig_mon_pkg;

    localparam int TRIG_MON_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2,
        ST_HOLD  = 2'd3
    } trig_state_e;

endpackage

// File: rtl/trig_edge_det.sv
// Two-flop sampler on the upstream event net plus rising-edge detect.
// A high level present at reset release produces exactly one rise pulse.
module trig_edge_det
    import trig_mon_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_evt,
    output logic o_rise
);

    logic r_evt_q;
    logic r_evt_q2;

    // NOTE: clocked state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_evt_q  <= 1'b0;
            r_evt_q2 <= 1'b0;
        end else begin
            r_evt_q  <= i_evt;
            r_evt_q2 <= r_evt_q;
        end
    end

    assign o_rise = r_evt_q & ~r_evt_q2;

endmodule

// File: rtl/trig_event_monitor.sv
// Counts event rises while armed and raises a held interrupt at the threshold.
// Optional idle-decay of the count is enabled with `define TRIG_MON_DECAY_EN.
module trig_event_monitor
    import trig_mon_pkg::*;
#(
    parameter int CNT_W  = TRIG_MON_CNT_W,
    parameter int WINDOW = 1000
) (
    input  logic             I1470,
    input  logic             I1477,
    input  logic             evt_in,
    input  logic             arm,
    input  logic             clr,
    input  logic [CNT_W-1:0] threshold,
    input  logic             irq_ack,
    output logic             irq_valid,
    output logic             fired,
    output logic [CNT_W-1:0] evt_count,
    output logic [1:0]       state
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ARMED = ST_ARMED;
    localparam logic [1:0] S_FIRED = ST_FIRED;
    localparam logic [1:0] S_HOLD  = ST_HOLD;

    logic [1:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt, w_count_inc, w_thr_eff;
    logic             r_fired, w_fired_nxt;
    logic             r_irq_valid, w_irq_valid_nxt;
    logic             w_rise;

    trig_edge_det u_edge_det (
        .i_clk   (I1470),
        .i_rst_n (I1477),
        .i_evt   (evt_in),
        .o_rise  (w_rise)
    );

`ifdef TRIG_MON_DECAY_EN
    localparam int TMR_W = $clog2(WINDOW + 1);
    logic [TMR_W-1:0] r_timer, w_timer_nxt, w_timer_inc;
    assign w_timer_inc = r_timer + 1'b1;
`else
    logic w_unused_window;
    assign w_unused_window = (WINDOW != 0);
`endif

    // Zero threshold behaves as one; the count saturates instead of wrapping.
    assign w_thr_eff   = (threshold == '0) ? CNT_W'(1) : threshold;
    assign w_count_inc = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + 1'b1;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_fired_nxt     = r_fired;
        w_irq_valid_nxt = r_irq_valid;
`ifdef TRIG_MON_DECAY_EN
        w_timer_nxt     = '0;
`endif
        if (clr) begin
            w_state_nxt     = S_IDLE;
            w_count_nxt     = '0;
            w_fired_nxt     = 1'b0;
            w_irq_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        w_state_nxt = S_ARMED;
                        w_count_nxt = '0;
                    end
                end
                S_ARMED: begin
                    if (w_rise) begin
                        w_count_nxt = w_count_inc;
                        if (w_count_inc >= w_thr_eff) begin
                            w_state_nxt     = S_FIRED;
                            w_fired_nxt     = 1'b1;
                            w_irq_valid_nxt = 1'b1;
                        end
                    end else begin
`ifdef TRIG_MON_DECAY_EN
                        if (w_timer_inc == TMR_W'(WINDOW)) begin
                            w_count_nxt = '0;
                        end else begin
                            w_timer_nxt = w_timer_inc;
                        end
`endif
                    end
                end
                S_FIRED: begin
                    if (irq_ack) begin
                        w_state_nxt     = S_HOLD;
                        w_irq_valid_nxt = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_fired     <= 1'b0;
            r_irq_valid <= 1'b0;
`ifdef TRIG_MON_DECAY_EN
            r_timer     <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_fired     <= w_fired_nxt;
            r_irq_valid <= w_irq_valid_nxt;
`ifdef TRIG_MON_DECAY_EN
            r_timer     <= w_timer_nxt;
`endif
        end
    end

    assign irq_valid = r_irq_valid;
    assign fired     = r_fired;
    assign evt_count = r_count;
    assign state     = r_state;

endmodule

// File: tb/tb_trig_event_monitor.sv
// Table-driven bench for trig_event_monitor with an expectation queue per cycle.
// Decay expectations follow whether TRIG_MON_DECAY_EN is defined for the build.
module tb_trig_event_monitor;

    typedef struct packed {
        logic [7:0] cnt;
        logic       irq;
        logic       fired;
        logic [1:0] st;
    } exp_t;

    typedef struct packed {
        logic       evt;
        logic       arm;
        logic       clr;
        logic       ack;
        logic [7:0] thr;
        exp_t       e;
    } vec_t;

`ifdef TRIG_MON_DECAY_EN
    localparam bit DECAY = 1'b1;
`else
    localparam bit DECAY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       evt_in, arm, clr, irq_ack;
    logic [7:0] threshold;
    logic       irq_valid, fired;
    logic [7:0] evt_count;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;
    exp_t  exp_q[$];
    string name_q[$];
    vec_t  tbl[$];

    trig_event_monitor #(.CNT_W(8), .WINDOW(20)) dut (
        .I1470     (clk),
        .I1477     (rst_n),
        .evt_in    (evt_in),
        .arm       (arm),
        .clr       (clr),
        .threshold (threshold),
        .irq_ack   (irq_ack),
        .irq_valid (irq_valid),
        .fired     (fired),
        .evt_count (evt_count),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk_exp(logic [7:0] cnt, logic irq, logic fd, logic [1:0] st);
        exp_t e;
        e.cnt = cnt; e.irq = irq; e.fired = fd; e.st = st;
        return e;
    endfunction

    function automatic vec_t mk(logic ev, logic ar, logic cl, logic ak, logic [7:0] thr,
                                logic [7:0] cnt, logic irq, logic fd, logic [1:0] st);
        vec_t v;
        v.evt = ev; v.arm = ar; v.clr = cl; v.ack = ak; v.thr = thr;
        v.e = mk_exp(cnt, irq, fd, st);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_out();
        exp_t  e;
        exp_t  act;
        string n;
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        act = {evt_count, irq_valid, fired, state};
        n_checks++;
        if (act !== e) begin
            n_errors++;
            $display("FAIL %s: got cnt=%0d irq=%0b fired=%0b st=%0d, expected cnt=%0d irq=%0b fired=%0b st=%0d",
                     n, act.cnt, act.irq, act.fired, act.st, e.cnt, e.irq, e.fired, e.st);
        end
    endtask

    task automatic step(input logic ev, input logic ar, input logic cl, input logic ak,
                        input logic [7:0] thr, input exp_t e, input string name);
        evt_in = ev; arm = ar; clr = cl; irq_ack = ak; threshold = thr;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; evt_in = 1'b0; arm = 1'b0; clr = 1'b0; irq_ack = 1'b0; threshold = 8'd0;
        #2;
        check("reset_state", 32'(state), 32'd0);
        check("reset_count", 32'(evt_count), 32'd0);
        check("reset_irq", 32'(irq_valid), 32'd0);
        check("reset_fired", 32'(fired), 32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Threshold 3, pulses every 4 cycles, then a held ack-less FIRED and HOLD.
        tbl.push_back(mk(0,1,0,0,3, 0,0,0,1));
        tbl.push_back(mk(1,0,0,0,3, 0,0,0,1));
        tbl.push_back(mk(0,0,0,0,3, 1,0,0,1));
        tbl.push_back(mk(0,0,0,0,3, 1,0,0,1));
        tbl.push_back(mk(0,0,0,0,3, 1,0,0,1));
        tbl.push_back(mk(1,0,0,0,3, 1,0,0,1));
        tbl.push_back(mk(0,0,0,0,3, 2,0,0,1));
        tbl.push_back(mk(0,0,0,0,3, 2,0,0,1));
        tbl.push_back(mk(0,0,0,0,3, 2,0,0,1));
        tbl.push_back(mk(1,0,0,0,3, 2,0,0,1));
        tbl.push_back(mk(0,0,0,0,3, 3,1,1,2));
        for (int i = 11; i <= 20; i++)
            tbl.push_back(mk(logic'(i % 2), logic'(i == 12), 0, 0, 3, 3,1,1,2));
        tbl.push_back(mk(0,0,0,1,3, 3,0,1,3));
        tbl.push_back(mk(1,0,0,0,3, 3,0,1,3));
        tbl.push_back(mk(0,1,0,0,3, 3,0,1,3));
        tbl.push_back(mk(0,0,0,0,3, 3,0,1,3));
        tbl.push_back(mk(0,0,1,0,3, 0,0,0,0));
        // Fire at threshold 1, then clr together with irq_ack and an event.
        tbl.push_back(mk(0,1,0,0,1, 0,0,0,1));
        tbl.push_back(mk(1,0,0,0,1, 0,0,0,1));
        tbl.push_back(mk(0,0,0,0,1, 1,1,1,2));
        tbl.push_back(mk(1,0,1,1,1, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 0,0,0,1));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,1));
        tbl.push_back(mk(0,0,1,0,1, 0,0,0,0));
        // Lowered threshold already met waits for the next counted edge.
        tbl.push_back(mk(0,1,0,0,5, 0,0,0,1));
        tbl.push_back(mk(1,0,0,0,5, 0,0,0,1));
        tbl.push_back(mk(0,0,0,0,5, 1,0,0,1));
        tbl.push_back(mk(0,0,0,0,1, 1,0,0,1));
        tbl.push_back(mk(1,0,0,0,1, 1,0,0,1));
        tbl.push_back(mk(0,0,0,0,1, 2,1,1,2));
        tbl.push_back(mk(0,0,1,0,1, 0,0,0,0));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].evt, tbl[i].arm, tbl[i].clr, tbl[i].ack, tbl[i].thr, tbl[i].e,
                 $sformatf("vec%0d", i));

        // Threshold 0 fires on the very first pulse; later pulses change nothing.
        step(0,1,0,0,0, mk_exp(0,0,0,1), "thr0_arm");
        for (int i = 1; i <= 300; i++) begin
            step(1,0,0,0,0, (i == 1) ? mk_exp(0,0,0,1) : mk_exp(1,1,1,2), $sformatf("thr0_hi%0d", i));
            step(0,0,0,0,0, mk_exp(1,1,1,2), $sformatf("thr0_lo%0d", i));
        end
        step(0,0,1,0,0, mk_exp(0,0,0,0), "thr0_clr");

        // Threshold 255 climbs to the top of the counter and fires there.
        step(0,1,0,0,255, mk_exp(0,0,0,1), "thr255_arm");
        for (int i = 1; i <= 300; i++) begin
            int prev;
            int cur;
            prev = (i - 1 > 255) ? 255 : i - 1;
            cur  = (i > 255) ? 255 : i;
            step(1,0,0,0,255, mk_exp(8'(prev), prev == 255, prev == 255, (prev == 255) ? 2'd2 : 2'd1),
                 $sformatf("thr255_hi%0d", i));
            step(0,0,0,0,255, mk_exp(8'(cur), cur == 255, cur == 255, (cur == 255) ? 2'd2 : 2'd1),
                 $sformatf("thr255_lo%0d", i));
        end
        step(0,0,1,0,255, mk_exp(0,0,0,0), "thr255_clr");

        // Two counted edges, then a full idle window.
        step(0,1,0,0,10, mk_exp(0,0,0,1), "decay_arm");
        for (int i = 1; i <= 2; i++) begin
            step(1,0,0,0,10, mk_exp(8'(i - 1),0,0,1), $sformatf("decay_hi%0d", i));
            step(0,0,0,0,10, mk_exp(8'(i),0,0,1), $sformatf("decay_lo%0d", i));
        end
        for (int i = 1; i <= 20; i++)
            step(0,0,0,0,10, mk_exp((DECAY && i == 20) ? 8'd0 : 8'd2, 0,0,1), $sformatf("decay_idle%0d", i));
        step(0,0,1,0,10, mk_exp(0,0,0,0), "decay_clr");

        // Asynchronous reset while the interrupt is pending.
        step(0,1,0,0,1, mk_exp(0,0,0,1), "ares_arm");
        step(1,0,0,0,1, mk_exp(0,0,0,1), "ares_hi");
        step(0,0,0,0,1, mk_exp(1,1,1,2), "ares_fire");
        #2;
        rst_n = 1'b0;
        #1;
        check("ares_irq", 32'(irq_valid), 32'd0);
        check("ares_fired", 32'(fired), 32'd0);
        check("ares_count", 32'(evt_count), 32'd0);
        check("ares_state", 32'(state), 32'd0);
        evt_in = 1'b1;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1,0,0,0,1, mk_exp(0,0,0,0), "rel_edge_idle");
        step(1,1,0,0,1, mk_exp(0,0,0,1), "rel_arm");
        step(1,0,0,0,1, mk_exp(0,0,0,1), "rel_held1");
        step(1,0,0,0,1, mk_exp(0,0,0,1), "rel_held2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trig_event_monitor.md
TRIG_EVENT_MONITOR -- requirements
Module: trig_event_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning event-counter and threshold width.
REQ-002 SHALL have parameter WINDOW, default 1000, meaning idle-cycle limit for the decay timer; used only when TRIG_MON_DECAY_EN is defined.
REQ-003 SHALL have port I1470  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port I1477  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port evt_in  input  1  single-bit event net from the upstream subcircuit output; synchronous to I1470.
REQ-006 SHALL have port arm  input  1  one-cycle request to start monitoring.
REQ-007 SHALL have port clr  input  1  one-cycle request to abort or clear monitoring.
REQ-008 SHALL have port threshold  input  CNT_W  number of evt_in rising edges that fires the monitor.
REQ-009 SHALL have port irq_ack  input  1  consumer acknowledge of irq_valid.
REQ-010 SHALL have port irq_valid  output  1  fire notification, held until acknowledged.
REQ-011 SHALL have port fired  output  1  sticky flag, set on fire, cleared only by clr or reset.
REQ-012 SHALL have port evt_count  output  CNT_W  current edge count.
REQ-013 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-014 SHALL register evt_in into evt_q and evt_q into evt_q2; edge = evt_q & ~evt_q2. A rise before clock edge k increments evt_count at edge k+1.
REQ-015 SHALL implement the FSM states IDLE=0, ARMED=1, FIRED=2 and HOLD=3.
REQ-016 SHALL transition IDLE->ARMED on arm=1, loading evt_count=0; an edge in that same cycle is not counted.
REQ-017 SHALL, in ARMED, increment evt_count by 1 on each edge, saturating at 2^CNT_W-1.
REQ-018 SHALL, in ARMED, when the incremented count is >= effective threshold, move to FIRED on that same clock edge, setting irq_valid=1 and fired=1. A threshold of 0 acts as 1.
REQ-019 SHALL sample threshold in ARMED every cycle; a lowered threshold already met fires on the next edge-counted cycle only.
REQ-020 SHALL hold irq_valid=1 in FIRED until irq_ack=1, then go to HOLD with irq_valid=0 on the next edge. irq_ack outside FIRED is ignored.
REQ-021 SHALL, in HOLD, ignore edges and arm, and keep fired=1 and evt_count frozen.
REQ-022 SHALL, on clr=1 in any state, go to IDLE with evt_count=0, fired=0 and irq_valid=0. clr has priority over arm, irq_ack and edges in the same cycle.
REQ-023 SHALL treat arm in ARMED, FIRED or HOLD as a no-op.

Reset
REQ-024 SHALL, on I1477=0, asynchronously force state=IDLE, evt_count=0, fired=0, irq_valid=0, evt_q=0, evt_q2=0 and the decay timer to 0.
REQ-025 SHALL, when reset asserts mid-operation (e.g. in FIRED with irq_valid=1), drop all outputs immediately without waiting for a clock.
REQ-026 SHALL not generate a spurious edge after deassertion if evt_in is held high: the first cycle sets evt_q=1 and evt_q2=0, so exactly one edge counts only once armed.

Configuration
REQ-027 SHALL, with TRIG_MON_DECAY_EN defined, in ARMED, count cycles without an edge using a timer of width clog2(WINDOW+1); when it reaches WINDOW, evt_count resets to 0, the timer resets, and the state stays ARMED. Any edge clears the timer.
REQ-028 SHALL, without TRIG_MON_DECAY_EN, have no timer logic and never decay evt_count; WINDOW is unused.

Structure
REQ-029 SHALL take the state enum type and encodings, and the default CNT_W, from shared package trig_mon_pkg.
REQ-030 SHALL place the two-flop sampler and rise detection in sub-module trig_edge_det, with the FSM and counter in the top level.

Verification
REQ-031 SHALL cover: reset, arm, threshold=3, three evt_in pulses of 1 cycle spaced 4 cycles -> evt_count 1,2,3; irq_valid=1 and fired=1 at the third count; state=2.
REQ-032 SHALL cover: in FIRED, irq_ack held 0 for 10 cycles, then 1 -> irq_valid stays 1 for those 10 cycles, then 0 next edge; state=3; further pulses leave evt_count=3.
REQ-033 SHALL cover: CNT_W=8, threshold=0, 300 pulses -> fires on first pulse; a rerun with threshold=255 and arm saturates evt_count at 255 and fires.
REQ-034 SHALL cover: clr and irq_ack asserted together in FIRED -> state=0, evt_count=0, fired=0, irq_valid=0 next edge.
REQ-035 SHALL cover: I1477 pulled low asynchronously mid-cycle while irq_valid=1 -> all outputs 0 before the next I1470 edge; evt_in held 1 through release, then arm -> evt_count stays 0.
REQ-036 SHALL cover, with TRIG_MON_DECAY_EN and WINDOW=20: 2 pulses, then 20 idle cycles -> evt_count returns to 0 and state=1; without the macro, evt_count stays 2.
